rvj1_hazard_ctrl: RTL

Parametrised hazard and program-counter controller for the rvj1 core. Tracks the destination registers of up to NSTAGES in-flight instructions, resolves read-after-write hazards on both source operands by forwarding or stalling, and owns the program counter with a branch/jump redirect path. It sits between decode and the execute/writeback pipeline and supersedes the fixed single-stage stall controller.

---
 rtl/rvj1_hazard_ctrl_pkg.sv | 25 ++
 rtl/rvj1_hazard_ctrl_if.sv | 43 ++++
 rtl/rvj1_hazard_match.sv | 35 +++
 rtl/rvj1_hazard_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/rvj1_hazard_ctrl_pkg.sv
// Shared types for the rvj1 hazard/PC controller: tracking entry layout and
// the operand forward-select encoding.
package rvj1_hazard_ctrl_pkg;

    // Widest register address a tracking entry can hold; narrower RALEN
    // values are zero-extended into it.
    localparam int RA_W       = 8;
    localparam int MAX_STAGES = 4;
    // Forward select holds 0..NSTAGES; $clog2(MAX_STAGES+1) = 3 bits.
    localparam int FWD_W      = $clog2(MAX_STAGES + 1);

    typedef logic [FWD_W-1:0] fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            late;
    } trk_entry_t;

    // Forward-select code for a match found at tracked stage k.
    function automatic fwd_sel_t fwd_code(input int k);
        return FWD_W'(k + 1);
    endfunction

endpackage

// File: rtl/rvj1_hazard_ctrl_if.sv
// Decode-side bundle between the issue logic and the hazard/PC controller.
interface rvj1_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int RALEN = 5
);
    import rvj1_hazard_ctrl_pkg::*;

    logic             issue_valid_i;
    logic [RALEN-1:0] rs1_addr_i;
    logic [RALEN-1:0] rs2_addr_i;
    logic             rs1_used_i;
    logic             rs2_used_i;
    logic [RALEN-1:0] rd_addr_i;
    logic             rd_wr_i;
    logic             rd_late_i;
    logic             redirect_i;
    logic [XLEN-1:0]  redirect_pc_i;

    logic             issue_fire_o;
    logic             stall_o;
    logic             flush_o;
    fwd_sel_t         fwd_a_o;
    fwd_sel_t         fwd_b_o;
    logic [XLEN-1:0]  program_counter_o;
    logic [31:0]      stall_cycles_o;

    // Decode / execute side: presents instructions and redirects.
    modport master (
        output issue_valid_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
               rd_addr_i, rd_wr_i, rd_late_i, redirect_i, redirect_pc_i,
        input  issue_fire_o, stall_o, flush_o, fwd_a_o, fwd_b_o,
               program_counter_o, stall_cycles_o
    );

    // Controller side.
    modport slave (
        input  issue_valid_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
               rd_addr_i, rd_wr_i, rd_late_i, redirect_i, redirect_pc_i,
        output issue_fire_o, stall_o, flush_o, fwd_a_o, fwd_b_o,
               program_counter_o, stall_cycles_o
    );

endinterface

// File: rtl/rvj1_hazard_match.sv
// Youngest-match search of one source operand against the tracking pipe.
// Produces the forward select and whether the operand must stall.
module rvj1_hazard_match
    import rvj1_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGES = 2,
    parameter int RALEN   = 5,
    parameter bit FWD_EN  = 1'b1
) (
    input  trk_entry_t [NSTAGES-1:0] trk_i,
    input  logic                     used_i,
    input  logic [RALEN-1:0]         addr_i,
    output fwd_sel_t                 fwd_o,
    output logic                     hazard_o
);

    logic found;

    // Scan from the youngest stage; the first valid rd match decides.
    always_comb begin
        fwd_o    = '0;
        hazard_o = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < NSTAGES; k++) begin
            if (!found && used_i && (addr_i != '0) && trk_i[k].valid &&
                (trk_i[k].rd == RA_W'(addr_i))) begin
                found    = 1'b1;
                fwd_o    = fwd_code(k);
                // A late result is only available once it reaches the last stage.
                hazard_o = !FWD_EN || (trk_i[k].late && (k < NSTAGES - 1));
            end
        end
    end

endmodule

// File: rtl/rvj1_hazard_ctrl.sv
// rvj1 hazard and program-counter controller. Tracks destination registers
// of in-flight instructions, resolves RAW hazards by forwarding or stalling,
// and owns the fetch PC including the branch/jump redirect path.
module rvj1_hazard_ctrl
    import rvj1_hazard_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              RALEN    = 5,
    parameter int              NSTAGES  = 2,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter bit              FWD_EN   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rvj1_hazard_ctrl_if.slave   hz
);

    trk_entry_t [NSTAGES-1:0] trk_q, trk_d;
    logic [XLEN-1:0]          pc_q, pc_d;
    logic [31:0]              cnt_q, cnt_d;

    logic hazard_a, hazard_b;
    logic stall, fire;

    rvj1_hazard_match #(
        .NSTAGES (NSTAGES),
        .RALEN   (RALEN),
        .FWD_EN  (FWD_EN)
    ) u_match_a (
        .trk_i    (trk_q),
        .used_i   (hz.rs1_used_i),
        .addr_i   (hz.rs1_addr_i),
        .fwd_o    (hz.fwd_a_o),
        .hazard_o (hazard_a)
    );

    rvj1_hazard_match #(
        .NSTAGES (NSTAGES),
        .RALEN   (RALEN),
        .FWD_EN  (FWD_EN)
    ) u_match_b (
        .trk_i    (trk_q),
        .used_i   (hz.rs2_used_i),
        .addr_i   (hz.rs2_addr_i),
        .fwd_o    (hz.fwd_b_o),
        .hazard_o (hazard_b)
    );

    // Issue control: a redirect kills decode and overrides any stall.
    always_comb begin
        stall = hz.issue_valid_i && (hazard_a || hazard_b) && !hz.redirect_i;
        fire  = hz.issue_valid_i && !stall && !hz.redirect_i;
    end

    assign hz.stall_o           = stall;
    assign hz.issue_fire_o      = fire;
    assign hz.flush_o           = hz.redirect_i;
    assign hz.program_counter_o = pc_q;
    assign hz.stall_cycles_o    = cnt_q;

    // Next tracking pipe: shift one stage, new entry (or bubble) at stage 0.
    always_comb begin
        trk_d = '0;
        for (int k = NSTAGES - 1; k > 0; k--) begin
            trk_d[k] = trk_q[k-1];
        end
        if (fire) begin
            trk_d[0].valid = hz.rd_wr_i && (hz.rd_addr_i != '0);
            trk_d[0].rd    = RA_W'(hz.rd_addr_i);
            trk_d[0].late  = hz.rd_late_i;
        end
    end

    // Next PC and saturating stall counter.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (hz.redirect_i) begin
            pc_d = hz.redirect_pc_i & ~XLEN'(3);
        end else if (fire) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State registers, asynchronously reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trk_q <= '0;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            trk_q <= trk_d;
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
